// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between the L1 I-cache and D-cache.
// One transaction is granted at a time and held until the memory side responds.
module l1_mem_arbiter #(
  parameter int unsigned s_addr = 32,
  parameter int unsigned s_line = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cl_read,
  input  logic [s_addr-1:0] i_cl_addr,
  output logic [s_line-1:0] i_cl_rdata,
  output logic              i_cl_resp,
  input  logic              d_cl_read,
  input  logic              d_cl_write,
  input  logic [s_addr-1:0] d_cl_addr,
  input  logic [s_line-1:0] d_cl_wdata,
  output logic [s_line-1:0] d_cl_rdata,
  output logic              d_cl_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [s_addr-1:0] mem_addr,
  output logic [s_line-1:0] mem_wdata,
  input  logic [s_line-1:0] mem_rdata,
  input  logic              mem_resp,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIRd, StDRd, StDWr} state_e;

  state_e state_q, state_d;
  // 0: I-cache served last, 1: D-cache served last.
  logic   last_grant_q, last_grant_d;
  logic   i_req, d_req;

  assign i_req = i_cl_read;
  assign d_req = d_cl_read | d_cl_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      StIdle: begin
        if (i_req && (!d_req || last_grant_q)) begin
          state_d = StIRd;
        end else if (d_req) begin
          // A simultaneous read and write from the D-cache resolves to the write-back.
          state_d = d_cl_write ? StDWr : StDRd;
        end
      end
      StIRd: begin
        if (mem_resp) begin
          state_d      = StIdle;
          last_grant_d = 1'b0;
        end
      end
      StDRd, StDWr: begin
        if (mem_resp) begin
          state_d      = StIdle;
          last_grant_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Memory-side outputs are forced to zero outside a grant.
  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_cl_resp = 1'b0;
    d_cl_resp = 1'b0;
    case (state_q)
      StIRd: begin
        mem_read  = 1'b1;
        mem_addr  = i_cl_addr;
        i_cl_resp = mem_resp;
      end
      StDRd: begin
        mem_read  = 1'b1;
        mem_addr  = d_cl_addr;
        d_cl_resp = mem_resp;
      end
      StDWr: begin
        mem_write = 1'b1;
        mem_addr  = d_cl_addr;
        mem_wdata = d_cl_wdata;
        d_cl_resp = mem_resp;
      end
      default: ;
    endcase
  end

  assign i_cl_rdata = mem_rdata;
  assign d_cl_rdata = mem_rdata;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomized scoreboard bench for l1_mem_arbiter: a transaction-level model predicts grants
// and responses; a negedge monitor compares them against what the DUT presents.
module tb_l1_mem_arbiter;

  localparam int SA = 32;
  localparam int SL = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_cl_read = 1'b0;
  logic [SA-1:0] i_cl_addr = '0;
  logic [SL-1:0] i_cl_rdata;
  logic          i_cl_resp;
  logic          d_cl_read = 1'b0;
  logic          d_cl_write = 1'b0;
  logic [SA-1:0] d_cl_addr = '0;
  logic [SL-1:0] d_cl_wdata = '0;
  logic [SL-1:0] d_cl_rdata;
  logic          d_cl_resp;
  logic          mem_read;
  logic          mem_write;
  logic [SA-1:0] mem_addr;
  logic [SL-1:0] mem_wdata;
  logic [SL-1:0] mem_rdata = '0;
  logic          mem_resp = 1'b0;
  logic          busy;

  l1_mem_arbiter #(.s_addr(SA), .s_line(SL)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_cl_read (i_cl_read),
    .i_cl_addr (i_cl_addr),
    .i_cl_rdata(i_cl_rdata),
    .i_cl_resp (i_cl_resp),
    .d_cl_read (d_cl_read),
    .d_cl_write(d_cl_write),
    .d_cl_addr (d_cl_addr),
    .d_cl_wdata(d_cl_wdata),
    .d_cl_rdata(d_cl_rdata),
    .d_cl_resp (d_cl_resp),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_resp  (mem_resp),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            wr;
    logic [SA-1:0] addr;
    logic [SL-1:0] wdata;
    int            start;
  } grant_t;

  typedef struct {
    bit            who;  // 0: I-cache, 1: D-cache
    logic [SL-1:0] data;
  } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Requester state held by the bench.
  bit            i_pend = 0, i_done = 0;
  bit            d_pend = 0, d_done = 0, d_wr = 0;
  logic [SA-1:0] i_addr_v = '0, d_addr_v = '0;
  logic [SL-1:0] d_wdata_v = '0;

  // Transaction-level view of the shared port.
  bit m_busy = 0;
  bit m_who = 0;
  bit m_last = 1;
  int m_lat = 0;
  bit exp_busy = 0;
  bit mon_en = 0;

  task automatic chk(input string name, input logic [SL-1:0] act, input logic [SL-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [SL-1:0] rand_line();
    logic [SL-1:0] r;
    for (int w = 0; w < SL / 32; w++) r[32*w +: 32] = $urandom();
    return r;
  endfunction

  // One cycle of stimulus: requesters, then the memory side and the arbitration prediction.
  task automatic step(input bit allow_new, input bit force_tie);
    grant_t g;
    resp_t  r;
    bit     who;
    @(posedge clk);
    #1;
    cyc++;
    if (i_done) begin i_pend = 0; i_done = 0; end
    if (d_done) begin d_pend = 0; d_done = 0; end
    if (!i_pend && allow_new && (force_tie || $urandom_range(3) == 0)) begin
      i_pend   = 1;
      i_addr_v = {$urandom()} & 32'hffff_ffe0;
    end
    if (!d_pend && allow_new && (force_tie || $urandom_range(3) == 0)) begin
      d_pend    = 1;
      d_wr      = force_tie ? 1'b0 : 1'($urandom_range(1));
      d_addr_v  = {$urandom()} & 32'hffff_ffe0;
      d_wdata_v = rand_line();
    end
    i_cl_read  = i_pend;
    i_cl_addr  = i_addr_v;
    d_cl_read  = d_pend & !d_wr;
    d_cl_write = d_pend & d_wr;
    d_cl_addr  = d_addr_v;
    d_cl_wdata = d_wdata_v;

    mem_resp  = 1'b0;
    mem_rdata = rand_line();
    exp_busy  = m_busy;
    if (m_busy) begin
      if (m_lat == 0) begin
        mem_resp = 1'b1;
        r.who    = m_who;
        r.data   = mem_rdata;
        resp_q.push_back(r);
        m_busy = 0;
        m_last = m_who;
        if (m_who) d_done = 1; else i_done = 1;
      end else begin
        m_lat--;
      end
    end else begin
      if ($urandom_range(7) == 0) mem_resp = 1'b1;  // stray response while idle
      if (i_pend || d_pend) begin
        who     = (i_pend && d_pend) ? !m_last : d_pend;
        g.wr    = who && d_wr;
        g.addr  = who ? d_addr_v : i_addr_v;
        g.wdata = d_wdata_v;
        g.start = cyc + 1;
        grant_q.push_back(g);
        m_busy = 1;
        m_who  = who;
        m_lat  = int'($urandom_range(3));
      end
    end
  endtask

  grant_t cur;
  resp_t  mr;
  bit     prev_act = 0;
  logic   act;

  always @(negedge clk) begin
    if (mon_en) begin
      act = mem_read | mem_write;
      chk("busy", 256'({busy, act}), 256'({exp_busy, exp_busy}));
      if (!exp_busy) begin
        chk("idle_rw", 256'({mem_read, mem_write}), 256'(0));
        chk("idle_addr", 256'(mem_addr), 256'(0));
        chk("idle_wdata", mem_wdata, 256'(0));
      end
      if (act && !prev_act) begin
        if (grant_q.size() == 0) begin
          chk("unexpected_grant", 256'({mem_read, mem_write}), 256'(0));
        end else begin
          cur = grant_q.pop_front();
          chk("grant_cycle", 256'(cyc), 256'(cur.start));
          chk("grant_kind", 256'({mem_read, mem_write}), cur.wr ? 256'(1) : 256'(2));
          chk("grant_addr", 256'(mem_addr), 256'(cur.addr));
          if (cur.wr) chk("grant_wdata", mem_wdata, cur.wdata);
        end
      end else if (act) begin
        chk("hold_addr", 256'(mem_addr), 256'(cur.addr));
      end
      prev_act = act;
      if (i_cl_resp || d_cl_resp || resp_q.size() != 0) begin
        if (resp_q.size() == 0) begin
          chk("stray_resp", 256'({i_cl_resp, d_cl_resp}), 256'(0));
        end else begin
          mr = resp_q.pop_front();
          chk("resp_who", 256'({i_cl_resp, d_cl_resp}), mr.who ? 256'(1) : 256'(2));
          chk("resp_data", mr.who ? d_cl_rdata : i_cl_rdata, mr.data);
        end
      end
    end
  end

  initial begin
    #2;
    chk("reset_outs", 256'({mem_read, mem_write, i_cl_resp, d_cl_resp, busy}), 256'(0));
    chk("reset_addr", 256'(mem_addr), 256'(0));
    chk("reset_wdata", mem_wdata, 256'(0));
    #10 rst = 1'b1;

    // Randomized phase; the very first cycle is a forced tie out of reset.
    mon_en = 1;
    step(1, 1);
    for (int k = 0; k < 3000; k++) step(1, 0);
    for (int t = 0; t < 64 && (i_pend || d_pend || m_busy); t++) step(0, 0);
    chk("drain_bound", 256'({i_pend, d_pend, m_busy}), 256'(0));
    step(0, 0);
    @(negedge clk);
    #1;
    mon_en = 0;
    chk("grant_q_empty", 256'(grant_q.size()), 256'(0));
    chk("resp_q_empty", 256'(resp_q.size()), 256'(0));

    // Reset in the middle of a D read.
    @(posedge clk);
    #1;
    mem_resp   = 1'b0;
    i_cl_read  = 1'b0;
    d_cl_write = 1'b0;
    d_cl_read  = 1'b1;
    d_cl_addr  = 32'h8000_0040;
    @(posedge clk);
    #1;
    chk("drd_grant", 256'({mem_read, mem_write, mem_addr}), 256'({2'b10, 32'h8000_0040}));
    #2 mem_resp = 1'b1;
    #1 chk("drd_resp_pass", 256'(d_cl_resp), 256'(1));
    rst = 1'b0;
    #1;
    chk("rst_async", 256'({mem_read, busy, d_cl_resp}), 256'(0));
    chk("rst_addr", 256'(mem_addr), 256'(0));
    mem_resp  = 1'b0;
    d_cl_read = 1'b0;
    #3 rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", 256'({busy, mem_read, mem_write}), 256'(0));
    end

    // Tie after reset goes to the I-cache, then the D-cache after one idle cycle.
    i_cl_read = 1'b1;
    i_cl_addr = 32'h0000_1000;
    d_cl_read = 1'b1;
    d_cl_addr = 32'h8000_0020;
    @(posedge clk);
    #1;
    chk("tie_i_first", 256'({mem_read, mem_addr}), 256'({1'b1, 32'h0000_1000}));
    mem_rdata = rand_line();
    mem_resp  = 1'b1;
    #1;
    chk("tie_i_resp", 256'({i_cl_resp, d_cl_resp}), 256'(2));
    @(posedge clk);
    #1;
    mem_resp  = 1'b0;
    i_cl_read = 1'b0;
    chk("turnaround_idle", 256'({busy, mem_read}), 256'(0));
    @(posedge clk);
    #1;
    chk("tie_d_second", 256'({mem_read, mem_addr}), 256'({1'b1, 32'h8000_0020}));
    mem_resp = 1'b1;
    #1;
    chk("tie_d_resp", 256'({i_cl_resp, d_cl_resp}), 256'(1));
    @(posedge clk);
    #1;
    mem_resp  = 1'b0;
    d_cl_read = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
